// File: rtl/axi_slave_ram_if.sv
// AXI-style bus bundle between a master (or axi_bus) and the axi_slave_ram responder.
// Addresses are word addresses; data is one 32-bit word per beat.
interface axi_slave_ram_if #(
  parameter int ID_WIDTH = 4
);
  // Write address channel
  logic [ID_WIDTH-1:0] wr_addr_id;
  logic [31:0]         wr_addr;
  logic [7:0]          wr_addr_len;
  logic [1:0]          wr_addr_burst;
  logic                wr_addr_valid;
  logic                wr_addr_ready;
  // Write data channel
  logic [31:0]         wr_data;
  logic [3:0]          wr_strb;
  logic                wr_data_last;
  logic                wr_data_valid;
  logic                wr_data_ready;
  // Write response channel
  logic [ID_WIDTH-1:0] wr_back_id;
  logic [1:0]          wr_back_resp;
  logic                wr_back_valid;
  logic                wr_back_ready;
  // Read address channel
  logic [ID_WIDTH-1:0] rd_addr_id;
  logic [31:0]         rd_addr;
  logic [7:0]          rd_addr_len;
  logic [1:0]          rd_addr_burst;
  logic                rd_addr_valid;
  logic                rd_addr_ready;
  // Read data channel
  logic [ID_WIDTH-1:0] rd_back_id;
  logic [31:0]         rd_data;
  logic [1:0]          rd_data_resp;
  logic                rd_data_last;
  logic                rd_data_valid;
  logic                rd_data_ready;

  modport master (
    output wr_addr_id, wr_addr, wr_addr_len, wr_addr_burst, wr_addr_valid,
    input  wr_addr_ready,
    output wr_data, wr_strb, wr_data_last, wr_data_valid,
    input  wr_data_ready,
    input  wr_back_id, wr_back_resp, wr_back_valid,
    output wr_back_ready,
    output rd_addr_id, rd_addr, rd_addr_len, rd_addr_burst, rd_addr_valid,
    input  rd_addr_ready,
    input  rd_back_id, rd_data, rd_data_resp, rd_data_last, rd_data_valid,
    output rd_data_ready
  );

  modport slave (
    input  wr_addr_id, wr_addr, wr_addr_len, wr_addr_burst, wr_addr_valid,
    output wr_addr_ready,
    input  wr_data, wr_strb, wr_data_last, wr_data_valid,
    output wr_data_ready,
    output wr_back_id, wr_back_resp, wr_back_valid,
    input  wr_back_ready,
    input  rd_addr_id, rd_addr, rd_addr_len, rd_addr_burst, rd_addr_valid,
    output rd_addr_ready,
    output rd_back_id, rd_data, rd_data_resp, rd_data_last, rd_data_valid,
    input  rd_data_ready
  );
endinterface

// File: rtl/axi_slave_ram.sv
// Word-addressed, byte-strobed RAM behind one AXI slave port.
// Independent write (AW/W/B) and read (AR/R) FSMs run concurrently; all bus outputs are registered.
module axi_slave_ram #(
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic           clk,
  input  logic           rstn,
  output logic           slave_clk,
  output logic           slave_rstn,
  axi_slave_ram_if.slave bus
);

  localparam int         DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [DEPTH_LOG2-1:0] idx_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;

  assign slave_clk  = clk;
  assign slave_rstn = rstn;

  logic [3:0][7:0] mem [DEPTH];

  // Upper address bits alias onto the RAM and are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.wr_addr[31:DEPTH_LOG2], bus.rd_addr[31:DEPTH_LOG2]};

  // ---------------------------------------------------------------- write path
  w_state_t            w_state, w_state_n;
  logic [ID_WIDTH-1:0] wr_id;
  idx_t                wr_ptr;
  logic [7:0]          wr_len;
  logic                wr_fixed;
  logic                wr_bad_burst;
  logic [8:0]          wr_cnt;
  logic                aw_hs, w_hs, b_hs, mem_we;

  assign aw_hs  = bus.wr_addr_valid && bus.wr_addr_ready;
  assign w_hs   = bus.wr_data_valid && bus.wr_data_ready;
  assign b_hs   = bus.wr_back_valid && bus.wr_back_ready;
  assign mem_we = w_hs && (wr_cnt <= {1'b0, wr_len});

  // NOTE: next state defaults to the current state before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_n = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs)                     w_state_n = W_DATA;
      W_DATA:  if (w_hs && bus.wr_data_last)  w_state_n = W_RESP;
      W_RESP:  if (b_hs)                      w_state_n = W_IDLE;
      default:                                w_state_n = W_IDLE;
    endcase
  end

  // NOTE: handshake outputs are decoded from the next state into flops, so they are registered yet line up with the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state           <= W_IDLE;
      bus.wr_addr_ready <= 1'b0;
      bus.wr_data_ready <= 1'b0;
      bus.wr_back_valid <= 1'b0;
    end else begin
      w_state           <= w_state_n;
      bus.wr_addr_ready <= (w_state_n == W_IDLE);
      bus.wr_data_ready <= (w_state_n == W_DATA);
      bus.wr_back_valid <= (w_state_n == W_RESP);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_id            <= '0;
      wr_ptr           <= '0;
      wr_len           <= '0;
      wr_fixed         <= 1'b0;
      wr_bad_burst     <= 1'b0;
      wr_cnt           <= '0;
      bus.wr_back_id   <= '0;
      bus.wr_back_resp <= RESP_OKAY;
    end else if (aw_hs) begin
      wr_id        <= bus.wr_addr_id;
      wr_ptr       <= bus.wr_addr[DEPTH_LOG2-1:0];
      wr_len       <= bus.wr_addr_len;
      wr_fixed     <= (bus.wr_addr_burst == 2'b00);
      wr_bad_burst <= bus.wr_addr_burst[1];
      wr_cnt       <= '0;
    end else if (w_hs) begin
      // Saturating count: anything at 256 is past the longest legal burst.
      if (wr_cnt != 9'h100) wr_cnt <= wr_cnt + 9'd1;
      if (!wr_fixed)        wr_ptr <= wr_ptr + idx_t'(1);
      if (bus.wr_data_last) begin
        bus.wr_back_id   <= wr_id;
        bus.wr_back_resp <= (wr_bad_burst || (wr_cnt != {1'b0, wr_len})) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  // NOTE: the RAM array has no reset; contents survive rstn and only the control state is cleared.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && bus.wr_strb[b]) mem[wr_ptr][b] <= bus.wr_data[8*b +: 8];
    end
  end

  // ----------------------------------------------------------------- read path
  r_state_t   r_state, r_state_n;
  idx_t       rd_ptr, rd_step;
  logic [7:0] rd_len;
  logic [7:0] rd_cnt;
  logic       rd_fixed;
  logic       ar_hs, r_hs;

  assign ar_hs   = bus.rd_addr_valid && bus.rd_addr_ready;
  assign r_hs    = bus.rd_data_valid && bus.rd_data_ready;
  assign rd_step = rd_fixed ? rd_ptr : rd_ptr + idx_t'(1);

  always_comb begin
    r_state_n = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs)                    r_state_n = R_FETCH;
      R_FETCH:                               r_state_n = R_DATA;
      R_DATA:  if (r_hs && bus.rd_data_last) r_state_n = R_IDLE;
      default:                               r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state           <= R_IDLE;
      bus.rd_addr_ready <= 1'b0;
      bus.rd_data_valid <= 1'b0;
    end else begin
      r_state           <= r_state_n;
      bus.rd_addr_ready <= (r_state_n == R_IDLE);
      bus.rd_data_valid <= (r_state_n == R_DATA);
    end
  end

  // The RAM read shares the clock edge with any write, so a same-word collision returns the old word.
  // On each accepted beat the following word is fetched at once, sustaining one beat per cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr           <= '0;
      rd_len           <= '0;
      rd_cnt           <= '0;
      rd_fixed         <= 1'b0;
      bus.rd_back_id   <= '0;
      bus.rd_data      <= '0;
      bus.rd_data_resp <= RESP_OKAY;
      bus.rd_data_last <= 1'b0;
    end else if (ar_hs) begin
      rd_ptr           <= bus.rd_addr[DEPTH_LOG2-1:0];
      rd_len           <= bus.rd_addr_len;
      rd_cnt           <= '0;
      rd_fixed         <= (bus.rd_addr_burst == 2'b00);
      bus.rd_back_id   <= bus.rd_addr_id;
      bus.rd_data_resp <= bus.rd_addr_burst[1] ? RESP_SLVERR : RESP_OKAY;
    end else if (r_state == R_FETCH) begin
      bus.rd_data      <= mem[rd_ptr];
      bus.rd_data_last <= (rd_len == 8'd0);
    end else if (r_state == R_DATA && r_hs) begin
      if (bus.rd_data_last) begin
        bus.rd_data_last <= 1'b0;
      end else begin
        rd_ptr           <= rd_step;
        rd_cnt           <= rd_cnt + 8'd1;
        bus.rd_data      <= mem[rd_step];
        bus.rd_data_last <= ((rd_cnt + 8'd1) == rd_len);
      end
    end
  end

endmodule
